// File: rtl/mult_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Timeout limit is this many cycles per operand bit.
  localparam int TIMEOUT_MULT = 4;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin grant selection; purely combinational.
module rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = 1'b0;
    case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one shift-add multiplier sequencer.
// Define MULT_ARB_TIMEOUT_EN to abort a job stuck in the wait states after 4*n cycles.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [1:0]     req,
  input  logic [n-1:0]   a0,
  input  logic [n-1:0]   b0,
  input  logic [n-1:0]   a1,
  input  logic [n-1:0]   b1,
  output logic [1:0]     ack,
  output logic [2*n-1:0] product,
  output logic           busy,
  output logic           err,
  output logic           mul_start,
  output logic [n-1:0]   mul_a,
  output logic [n-1:0]   mul_b,
  input  logic           mul_ready,
  input  logic [2*n-1:0] mul_product
);

  state_t         r_state;
  logic           r_last;
  logic           r_grant;
  logic [1:0]     r_ack;
  logic [2*n-1:0] r_product;
  logic           r_busy;
  logic           r_err;
  logic           r_start;
  logic [n-1:0]   r_mul_a;
  logic [n-1:0]   r_mul_b;
  logic           w_grant;
  logic           w_valid;
  logic           w_timeout;

  rr_pick u_pick (
    .i_req        (req),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int LIM = TIMEOUT_MULT * n;
  localparam int CW  = $clog2(LIM + 1);
  logic [CW-1:0] r_cnt;

  // One shared count spans both wait states; it is zero on entry to WAIT_LO.
  assign w_timeout = (r_state == WAIT_LO || r_state == WAIT_HI) && (r_cnt == CW'(LIM - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if ((r_state == WAIT_LO || r_state == WAIT_HI) && !w_timeout)
      r_cnt <= r_cnt + 1'b1;
    else
      r_cnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_ack     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
    end else begin
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: if (w_valid) begin
          r_grant <= w_grant;
          r_mul_a <= w_grant ? a1 : a0;
          r_mul_b <= w_grant ? b1 : b0;
          r_start <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= START;
        end
        START: r_state <= WAIT_LO;
        WAIT_LO, WAIT_HI: begin
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_last  <= r_grant;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_state == WAIT_LO) begin
            if (!mul_ready) r_state <= WAIT_HI;
          end else if (mul_ready) begin
            r_product <= mul_product;
            r_ack     <= 2'(2'b01 << r_grant);
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_last  <= r_grant;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign product   = r_product;
  assign busy      = r_busy;
  assign err       = r_err;
  assign mul_start = r_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a simple multiplier sequencer model.
module tb_mult_arbiter;

  localparam int N = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [1:0]     req = '0;
  logic [N-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]     ack;
  logic [2*N-1:0] product;
  logic           busy, err, mul_start;
  logic [N-1:0]   mul_a, mul_b;
  logic           mul_ready = 1'b1;
  logic [2*N-1:0] mul_product = '0;

  int n_checks = 0;
  int n_errs   = 0;
  int n_start  = 0;
  int n_ack    = 0;
  int n_errp   = 0;

  logic           m_stuck = 1'b0;
  int             m_left  = 0;
  logic [2*N-1:0] m_prod  = '0;

  mult_arbiter #(.n(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .a0          (a0),
    .b0          (b0),
    .a1          (a1),
    .b1          (b1),
    .ack         (ack),
    .product     (product),
    .busy        (busy),
    .err         (err),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_ready   (mul_ready),
    .mul_product (mul_product)
  );

  always #5 clock = ~clock;

  // Sequencer model: ready drops after start, returns 8 cycles later with the product.
  always @(negedge clock) begin
    if (reset) begin
      mul_ready = 1'b1;
      m_left    = 0;
    end else if (mul_start && !m_stuck) begin
      mul_ready = 1'b0;
      m_left    = 8;
      m_prod    = 16'(mul_a) * 16'(mul_b);
    end else if (m_left != 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        mul_ready   = 1'b1;
        mul_product = m_prod;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (mul_start) n_start++;
      if (ack != 0)  n_ack++;
      if (err)       n_errp++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ack(output logic [1:0] a);
    a = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (ack != 0) begin
        a = ack;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] a;
    int s0, k0, cyc;

    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_ack", ack, 0);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    reset = 1'b0;

    // Single request from requester 0
    do_reset();
    s0 = n_start; k0 = n_ack;
    a0 = 3; b0 = 5; req = 2'b01;
    @(negedge clock);
    chk("single_start", mul_start, 1);
    chk("single_busy", busy, 1);
    chk("single_mul_a", mul_a, 3);
    wait_ack(a);
    req = '0;
    chk("single_ack", a, 2'b01);
    chk("single_product", product, 15);
    repeat (3) @(negedge clock);
    chk("single_idle", busy, 0);
    chk("single_nstart", n_start - s0, 1);
    chk("single_nack", n_ack - k0, 1);
    chk("single_hold", product, 15);

    // Contention: 0 first, then 1, then 0 again
    do_reset();
    s0 = n_start;
    a0 = 3; b0 = 5; a1 = 7; b1 = 9; req = 2'b11;
    wait_ack(a);
    chk("cont_ack1", a, 2'b01);
    chk("cont_prod1", product, 15);
    wait_ack(a);
    chk("cont_ack2", a, 2'b10);
    chk("cont_prod2", product, 63);
    wait_ack(a);
    req = '0;
    chk("cont_ack3", a, 2'b01);
    chk("cont_prod3", product, 15);
    repeat (3) @(negedge clock);
    chk("cont_nstart", n_start - s0, 3);

    // Back-to-back on requester 1
    do_reset();
    s0 = n_start;
    req = 2'b10;
    wait_ack(a);
    chk("b2b_ack1", a, 2'b10);
    chk("b2b_prod1", product, 63);
    wait_ack(a);
    req = '0;
    chk("b2b_ack2", a, 2'b10);
    chk("b2b_prod2", product, 63);
    repeat (3) @(negedge clock);
    chk("b2b_nstart", n_start - s0, 2);

    // Operand change mid-job
    do_reset();
    a0 = 3; b0 = 5; req = 2'b01;
    repeat (4) @(negedge clock);
    a0 = 200;
    @(negedge clock);
    chk("stab_mul_a", mul_a, 3);
    wait_ack(a);
    req = '0;
    chk("stab_ack", a, 2'b01);
    chk("stab_prod", product, 15);
    a0 = 3;

    // Reset in WAIT_HI
    do_reset();
    a0 = 3; b0 = 5; req = 2'b01;
    repeat (4) @(negedge clock);
    chk("mrst_busy_before", busy, 1);
    k0 = n_ack;
    reset = 1'b1;
    req   = '0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_ack", ack, 0);
    chk("mrst_mul_a", mul_a, 0);
    chk("mrst_mul_b", mul_b, 0);
    chk("mrst_product", product, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    chk("mrst_noack", n_ack - k0, 0);
    a1 = 7; b1 = 9; req = 2'b10;
    wait_ack(a);
    req = '0;
    chk("mrst_new_ack", a, 2'b10);
    chk("mrst_new_prod", product, 63);

    // Sequencer that never drops ready
    do_reset();
    m_stuck = 1'b1;
    k0 = n_ack;
    req = 2'b01;
`ifdef MULT_ARB_TIMEOUT_EN
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (err) begin
        cyc = i;
        break;
      end
    end
    req = '0;
    chk("tmo_cycle", cyc, 34);
    chk("tmo_busy", busy, 0);
    chk("tmo_ack", ack, 0);
    @(negedge clock);
    chk("tmo_pulse", err, 0);
    chk("tmo_noack", n_ack - k0, 0);
`else
    cyc = 0;
    repeat (40) @(negedge clock);
    chk("hang_busy", busy, 1);
    chk("hang_noack", n_ack - k0, 0);
    chk("hang_err", n_errp, 0);
`endif
    m_stuck = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
